// File: rtl/div_iter_if.sv
// div_iter_if: request/response bundle between an issuing pipeline and the
// iterative divider. The master drives operands and control, the slave
// returns the result, the pulse that marks it valid, and the busy flag.
interface div_iter_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic [XLEN-1:0]   dividend_i;
  logic [XLEN-1:0]   divisor_i;
  logic [2:0]        op_i;
  logic              start_i;
  logic [REG_AW-1:0] reg_waddr_i;
  logic              flush_i;
  logic [XLEN-1:0]   result_o;
  logic              ready_o;
  logic              busy_o;
  logic [REG_AW-1:0] reg_waddr_o;

  modport master (
    output dividend_i, divisor_i, op_i, start_i, reg_waddr_i, flush_i,
    input  result_o, ready_o, busy_o, reg_waddr_o
  );

  modport slave (
    input  dividend_i, divisor_i, op_i, start_i, reg_waddr_i, flush_i,
    output result_o, ready_o, busy_o, reg_waddr_o
  );
endinterface

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider for the RISC-V DIV/DIVU/REM/REMU
// group. One quotient bit per cycle on operand magnitudes; signs are
// restored in the final cycle. Divide-by-zero and signed overflow bypass
// the iteration and complete one cycle after acceptance.
module div_iter #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input logic   clk,
  input logic   rst,
  div_iter_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_END} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              special_q, special_d;

  logic              op_signed, op_rem;
  logic              dvd_neg, dvs_neg;
  logic              div_zero, overflow;
  logic [XLEN-1:0]   dvd_mag, dvs_mag, special_res;

  logic [XLEN:0]     shifted, diff;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;
  logic              ready;

  // Decode the incoming request: operation class, magnitudes, special cases
  always_comb begin
    op_signed   = (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
    op_rem      = (bus.op_i == 3'b110) || (bus.op_i == 3'b111);
    dvd_neg     = op_signed && bus.dividend_i[XLEN-1];
    dvs_neg     = op_signed && bus.divisor_i[XLEN-1];
    dvd_mag     = dvd_neg ? -bus.dividend_i : bus.dividend_i;
    dvs_mag     = dvs_neg ? -bus.divisor_i : bus.divisor_i;
    div_zero    = (bus.divisor_i == '0);
    overflow    = op_signed && (bus.dividend_i == MIN_NEG) && (bus.divisor_i == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = op_rem ? bus.dividend_i : '1;
    end else if (overflow) begin
      special_res = op_rem ? '0 : bus.dividend_i;
    end
  end

  // One restoring step on the partial remainder, plus final sign fix-up
  always_comb begin
    shifted   = {rem_q, quo_q[XLEN-1]};
    diff      = shifted - {1'b0, dvs_q};
    quo_fix   = neg_quo_q ? -quo_q : quo_q;
    rem_fix   = neg_rem_q ? -rem_q : rem_q;
    final_res = special_q ? quo_q : (is_rem_q ? rem_fix : quo_fix);
  end

  // Next-state and datapath update for the IDLE/CALC/END sequence
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    waddr_d   = waddr_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    special_d = special_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          waddr_d   = bus.reg_waddr_i;
          is_rem_d  = op_rem;
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
          cnt_d     = '0;
          rem_d     = '0;
          dvs_d     = dvs_mag;
          if (div_zero || overflow) begin
            quo_d     = special_res;
            special_d = 1'b1;
            state_d   = S_END;
          end else begin
            quo_d     = dvd_mag;
            special_d = 1'b0;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_END;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      waddr_q   <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      special_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      waddr_q   <= waddr_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      special_q <= special_d;
    end
  end

  assign ready           = (state_q == S_END) && !bus.flush_i;
  assign bus.ready_o     = ready;
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.result_o    = ready ? final_res : '0;
  assign bus.reg_waddr_o = (state_q != S_IDLE) ? waddr_q : '0;

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: scoreboard bench for div_iter at XLEN=32 and XLEN=8.
module tb_div_iter;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  typedef struct {
    logic [63:0] result;
    logic [4:0]  waddr;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cycle = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   hold_start = 1'b0;
  exp_t q32[$];
  exp_t q8[$];

  div_iter_if #(.XLEN(32), .REG_AW(5)) bus();
  div_iter_if #(.XLEN(8),  .REG_AW(5)) bus8();

  div_iter #(.XLEN(32), .REG_AW(5)) dut  (.clk(clk), .rst(rst), .bus(bus));
  div_iter #(.XLEN(8),  .REG_AW(5)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  // Free-running clock and cycle index
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: RISC-V division semantics with plain integer arithmetic
  function automatic logic [63:0] wmask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sext(input int w, input logic [63:0] v);
    return v[w-1] ? longint'(v | ~wmask(w)) : longint'(v);
  endfunction

  function automatic bit sgn_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic bit rem_op(input logic [2:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic bit is_special(input int w, input logic [2:0] op,
                                    input logic [63:0] a, input logic [63:0] b);
    longint min_neg;
    min_neg = -(longint'(1) <<< (w - 1));
    return (b == 64'd0) || (sgn_op(op) && sext(w, a) == min_neg && sext(w, b) == -1);
  endfunction

  function automatic logic [63:0] ref_model(input int w, input logic [2:0] op,
                                            input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    sa = sext(w, a);
    sb = sext(w, b);
    if (b == 64'd0) return rem_op(op) ? a : wmask(w);
    if (sgn_op(op)) begin
      if (is_special(w, op, a, b)) return rem_op(op) ? 64'd0 : a;
      return rem_op(op) ? (64'(sa % sb) & wmask(w)) : (64'(sa / sb) & wmask(w));
    end
    return rem_op(op) ? (a % b) : (a / b);
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor for the 32-bit instance: pop and compare on every ready pulse
  always @(negedge clk) begin
    exp_t e;
    if (bus.ready_o === 1'b1) begin
      if (q32.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_ready32: got result 0x%0h, want no pulse", bus.result_o);
      end else begin
        e = q32.pop_front();
        check("result32",  64'(bus.result_o),    e.result & 64'hFFFF_FFFF);
        check("waddr32",   64'(bus.reg_waddr_o), 64'(e.waddr));
        check("latency32", 64'(cycle),           64'(e.due));
      end
    end else if (bus.busy_o === 1'b0) begin
      check("idle_result32", 64'(bus.result_o),    64'd0);
      check("idle_waddr32",  64'(bus.reg_waddr_o), 64'd0);
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (bus8.ready_o === 1'b1) begin
      if (q8.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_ready8: got result 0x%0h, want no pulse", bus8.result_o);
      end else begin
        e = q8.pop_front();
        check("result8",  64'(bus8.result_o),    e.result & 64'hFF);
        check("waddr8",   64'(bus8.reg_waddr_o), 64'(e.waddr));
        check("latency8", 64'(cycle),            64'(e.due));
      end
    end else if (bus8.busy_o === 1'b0) begin
      check("idle_result8", 64'(bus8.result_o), 64'd0);
    end
  end

  // Wait for the 32-bit divider to go idle, scrambling operands meanwhile
  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy_o !== 1'b0 && n < 200) begin
      bus.start_i     = hold_start && !bus.ready_o;
      bus.dividend_i  = $urandom;
      bus.divisor_i   = $urandom;
      bus.op_i        = 3'($urandom);
      bus.reg_waddr_i = 5'($urandom);
      @(posedge clk); #1;
      n++;
    end
    bus.start_i = 1'b0;
    if (bus.busy_o !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL idle_timeout32: got busy 0x%0h, want 0x0", bus.busy_o);
    end
  endtask

  // Issue one 32-bit request, optionally recording its expected response
  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] wa, input bit push);
    exp_t e;
    wait_idle();
    bus.op_i        = op;
    bus.dividend_i  = a;
    bus.divisor_i   = b;
    bus.reg_waddr_i = wa;
    bus.start_i     = 1'b1;
    if (push) begin
      e.result = ref_model(32, op, 64'(a), 64'(b));
      e.waddr  = wa;
      e.due    = cycle + (is_special(32, op, 64'(a), 64'(b)) ? 1 : 33);
      q32.push_back(e);
    end
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  // Issue one 8-bit request and record its expected response
  task automatic apply8(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [4:0] wa);
    exp_t e;
    int n;
    n = 0;
    while (bus8.busy_o !== 1'b0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus8.busy_o !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL idle_timeout8: got busy 0x%0h, want 0x0", bus8.busy_o);
    end
    bus8.op_i        = op;
    bus8.dividend_i  = a;
    bus8.divisor_i   = b;
    bus8.reg_waddr_i = wa;
    bus8.start_i     = 1'b1;
    e.result = ref_model(8, op, 64'(a), 64'(b));
    e.waddr  = wa;
    e.due    = cycle + (is_special(8, op, 64'(a), 64'(b)) ? 1 : 9);
    q8.push_back(e);
    @(posedge clk); #1;
    bus8.start_i = 1'b0;
  endtask

  // Main stimulus sequence
  initial begin
    bus.dividend_i = '0;  bus.divisor_i = '0;  bus.op_i = '0;
    bus.start_i = 1'b0;   bus.reg_waddr_i = '0; bus.flush_i = 1'b0;
    bus8.dividend_i = '0; bus8.divisor_i = '0; bus8.op_i = '0;
    bus8.start_i = 1'b0;  bus8.reg_waddr_i = '0; bus8.flush_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",  64'(bus.busy_o),      64'd0);
    check("reset_ready", 64'(bus.ready_o),     64'd0);
    check("reset_res",   64'(bus.result_o),    64'd0);
    check("reset_waddr", 64'(bus.reg_waddr_o), 64'd0);

    // First start on the very first edge with reset released
    rst = 1'b1;
    apply_stimulus(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1);
    apply_stimulus(OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1);
    apply_stimulus(OP_REMU, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1);
    apply_stimulus(OP_DIVU, 32'd100,       32'd7, 5'd8, 1'b1);
    apply_stimulus(3'b000,  32'd1000,      32'd9, 5'd9, 1'b1);
    apply_stimulus(OP_DIVU, 32'h1234,      32'd0, 5'd10, 1'b1);
    apply_stimulus(OP_REM,  32'h1234,      32'd0, 5'd11, 1'b1);
    apply_stimulus(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1);
    apply_stimulus(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1);
    apply_stimulus(OP_DIV,  32'd7,         32'hFFFF_FFFE, 5'd14, 1'b1);

    // Flush mid-CALC: abort, then a fresh operation completes normally
    apply_stimulus(OP_DIV, 32'd100, 32'd3, 5'd15, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    check("flush_calc_busy", 64'(bus.busy_o), 64'd0);
    apply_stimulus(OP_DIV, 32'd9, 32'd3, 5'd16, 1'b1);

    // Flush in the END cycle suppresses that cycle's pulse
    apply_stimulus(OP_DIVU, 32'd50, 32'd5, 5'd17, 1'b0);
    repeat (32) @(posedge clk);
    #1;
    check("end_ready_before_flush", 64'(bus.ready_o), 64'd1);
    bus.flush_i = 1'b1;
    #1;
    check("end_ready_flushed", 64'(bus.ready_o), 64'd0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    check("flush_end_busy", 64'(bus.busy_o), 64'd0);

    // Flush and start together in IDLE: not accepted
    wait_idle();
    bus.op_i = OP_DIVU; bus.dividend_i = 32'd10; bus.divisor_i = 32'd2;
    bus.start_i = 1'b1; bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    check("flush_start_busy", 64'(bus.busy_o), 64'd0);

    // Reset mid-CALC clears every output
    apply_stimulus(OP_DIV, 32'd12345, 32'd17, 5'd18, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy",  64'(bus.busy_o),      64'd0);
    check("midrst_ready", 64'(bus.ready_o),     64'd0);
    check("midrst_res",   64'(bus.result_o),    64'd0);
    check("midrst_waddr", 64'(bus.reg_waddr_o), 64'd0);
    rst = 1'b1;

    // start_i held high while busy must not queue extra operations
    hold_start = 1'b1;
    for (int i = 0; i < 6; i++)
      apply_stimulus(3'($urandom_range(4, 7)), pick32(), pick32(), 5'($urandom), 1'b1);
    hold_start = 1'b0;

    // Randomized back-to-back traffic
    for (int i = 0; i < 60; i++)
      apply_stimulus(3'($urandom_range(0, 7)), pick32(), pick32(), 5'($urandom), 1'b1);
    wait_idle();

    // Narrow instance
    apply8(OP_DIV,  8'h80, 8'hFF, 5'd3);
    apply8(OP_DIVU, 8'd200, 8'd10, 5'd4);
    for (int i = 0; i < 20; i++)
      apply8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
             5'($urandom));
    repeat (12) @(posedge clk);
    #1;

    check("q32_drained", 64'(q32.size()), 64'd0);
    check("q8_drained",  64'(q8.size()),  64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got cycle %0d, want completion", cycle);
    $fatal(1);
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits (legal: 8..64, even).
REQ-002 Parameter REG_AW, default 5, destination register address width.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-low reset; sampled on rising edge of clk.
REQ-006 dividend_i  input  XLEN  dividend; sampled only on accepted start.
REQ-007 divisor_i  input  XLEN  divisor; sampled only on accepted start.
REQ-008 op_i  input  3  RISC-V funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU; others treated as DIVU.
REQ-009 start_i  input  1  start request; accepted only in IDLE.
REQ-010 reg_waddr_i  input  REG_AW  destination register; captured on accepted start.
REQ-011 flush_i  input  1  abort in-flight operation (jump/interrupt kill).
REQ-012 result_o  output  XLEN  quotient or remainder; valid only while ready_o=1, else 0.
REQ-013 ready_o  output  1  one-cycle result-valid pulse.
REQ-014 busy_o  output  1  high while an accepted operation is in flight.
REQ-015 reg_waddr_o  output  REG_AW  captured destination; valid while busy_o or ready_o, else 0.

Function
REQ-016 The block SHALL implement FSM states IDLE, CALC, END.
REQ-017 IDLE: start_i=1 and flush_i=0 -> accept; capture operands, op, reg_waddr; go to CALC (normal) or END (special case).
REQ-018 Special cases: divisor=0, or signed op with dividend=2^(XLEN-1) and divisor=all-ones.
REQ-019 Divide by zero: DIV/DIVU result all-ones; REM/REMU result = dividend.
REQ-020 Signed overflow: DIV result = dividend (2^(XLEN-1)); REM result 0.
REQ-021 CALC: one restoring-division step per cycle on magnitudes (signed ops take absolute values at accept); exactly XLEN cycles, counter 0..XLEN-1, then END.
REQ-022 END: apply sign: quotient negated if dividend and divisor signs differ (signed ops), remainder takes dividend sign; drive ready_o=1 and result_o for exactly one cycle; return to IDLE.
REQ-023 Latency: start accepted cycle T -> ready_o at T+XLEN+1 (normal), T+1 (special).
REQ-024 busy_o SHALL be 1 in CALC and END, 0 in IDLE.
REQ-025 start_i while busy_o=1 SHALL be ignored; no queuing.
REQ-026 flush_i=1 in CALC or END SHALL return FSM to IDLE next cycle; no ready_o pulse for the aborted operation; flush in END cycle suppresses that cycle's ready_o.
REQ-027 flush_i and start_i both 1 in IDLE: flush wins, start not accepted.
REQ-028 Operand inputs changing during CALC SHALL not affect the result.
REQ-029 Back-to-back: a new start accepted in the IDLE cycle immediately following END.
REQ-030 All arithmetic internal width XLEN+1 for partial remainder; no truncation of the XLEN result.

Reset
REQ-031 rst=0 at any rising edge SHALL force IDLE, counter 0, result_o=0, ready_o=0, busy_o=0, reg_waddr_o=0, including mid-CALC.
REQ-032 The first start SHALL be accepted on the first edge with rst=1.

Verification
REQ-033 XLEN=32, DIV -7/2, reg_waddr 5 -> ready_o at T+33, result 0xFFFFFFFD, reg_waddr_o 5.
REQ-034 REM -7/2 -> 0xFFFFFFFF; REMU 0xFFFFFFF9/2 -> 1; DIVU 100/7 -> 14.
REQ-035 DIVU 0x1234/0 -> ready_o at T+1, result 0xFFFFFFFF; REM 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1.
REQ-036 Start DIV 100/3, flush_i at T+10 -> busy_o=0 at T+11, no ready_o; next start 9/3 -> result 3 at its T+33.
REQ-037 rst=0 at T+5 of an operation -> all outputs 0 next cycle; start_i held high during busy ignored (single ready_o per accepted start).
REQ-038 XLEN=8 instance: DIV 0x80/0xFF -> 0x80 at T+1; DIVU 200/10 -> 20 at T+9.
